// File: rtl/rs_int_station.sv
`default_nettype none
// ============================================================================
// Module   : rs_int_station
// Purpose  : Integer reservation station. Holds dispatched integer ops until
//            both source operands are available, captures operands from the
//            CDB by ROB tag, and issues one ready op per cycle to the ALU.
// Ports    : clk, rst_n (async, active-low), flush (sync)
//            dispatch  : we, in_op, in_dest_tag, in_src{1,2}_{val,tag,rdy}
//            CDB       : cdb_valid, cdb_tag, cdb_data
//            issue     : issue_ready -> issue_valid, issue_op, issue_dest_tag,
//                        issue_src1, issue_src2
//            status    : is_full, count
// Options  : RS_INT_AGE_EN - oldest-ready-first select using per-entry
//            saturating age counters (default: lowest-index-ready select).
// Revision : 1.0 - initial release
// ============================================================================
module rs_int_station #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        we,
    input  logic [OP_W-1:0]             in_op,
    input  logic [TAG_W-1:0]            in_dest_tag,
    input  logic [DATA_W-1:0]           in_src1_val,
    input  logic [DATA_W-1:0]           in_src2_val,
    input  logic [TAG_W-1:0]            in_src1_tag,
    input  logic [TAG_W-1:0]            in_src2_tag,
    input  logic                        in_src1_rdy,
    input  logic                        in_src2_rdy,
    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [DATA_W-1:0]           cdb_data,
    input  logic                        issue_ready,
    output logic                        issue_valid,
    output logic [OP_W-1:0]             issue_op,
    output logic [TAG_W-1:0]            issue_dest_tag,
    output logic [DATA_W-1:0]           issue_src1,
    output logic [DATA_W-1:0]           issue_src2,
    output logic                        is_full,
    output logic [$clog2(ENTRIES):0]    count
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ENTRIES);

    // Entry storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] rdy1_q,  rdy1_d;
    logic [ENTRIES-1:0] rdy2_q,  rdy2_d;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [OP_W-1:0]    op_d   [ENTRIES];
    logic [TAG_W-1:0]   dest_q [ENTRIES];
    logic [TAG_W-1:0]   dest_d [ENTRIES];
    logic [TAG_W-1:0]   tag1_q [ENTRIES];
    logic [TAG_W-1:0]   tag1_d [ENTRIES];
    logic [TAG_W-1:0]   tag2_q [ENTRIES];
    logic [TAG_W-1:0]   tag2_d [ENTRIES];
    logic [DATA_W-1:0]  val1_q [ENTRIES];
    logic [DATA_W-1:0]  val1_d [ENTRIES];
    logic [DATA_W-1:0]  val2_q [ENTRIES];
    logic [DATA_W-1:0]  val2_d [ENTRIES];
    logic [CNT_W-1:0]   count_q, count_d;
`ifdef RS_INT_AGE_EN
    logic [IDX_W-1:0]   age_q  [ENTRIES];
    logic [IDX_W-1:0]   age_d  [ENTRIES];
    logic [IDX_W-1:0]   w_sel_age;
`endif

    logic [ENTRIES-1:0] w_ready;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_fire;
    logic               w_wr;
    logic               w_byp1;
    logic               w_byp2;

    assign w_ready = valid_q & rdy1_q & rdy2_q;

    // Select among ready entries (registered state only, so a CDB match in
    // this cycle cannot influence this cycle's selection).
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
`ifdef RS_INT_AGE_EN
        w_sel_age   = '0;
        // Strict '>' keeps the lowest index on equal ages.
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_ready[i] && (!w_sel_found || (age_q[i] > w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = age_q[i];
            end
        end
`else
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
`endif
    end

    // Lowest free slot, judged on pre-issue state so a slot being issued is
    // never reused in the same cycle.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    assign is_full = (count_q == FULL_COUNT);
    assign count   = count_q;
    assign w_fire  = w_sel_found & issue_ready;
    assign w_wr    = we & ~flush & ~is_full & w_free_found;
    assign w_byp1  = ~in_src1_rdy & cdb_valid & (in_src1_tag == cdb_tag);
    assign w_byp2  = ~in_src2_rdy & cdb_valid & (in_src2_tag == cdb_tag);

    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        op_d    = op_q;
        dest_d  = dest_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        count_d = count_q;
`ifdef RS_INT_AGE_EN
        age_d   = age_q;
`endif
        if (flush) begin
            valid_d = '0;
            count_d = '0;
`ifdef RS_INT_AGE_EN
            for (int i = 0; i < ENTRIES; i++) age_d[i] = '0;
`endif
        end else begin
            // Wakeup: both sources of an entry may capture in one cycle.
            for (int i = 0; i < ENTRIES; i++) begin
                if (cdb_valid && valid_q[i]) begin
                    if (!rdy1_q[i] && (tag1_q[i] == cdb_tag)) begin
                        rdy1_d[i] = 1'b1;
                        val1_d[i] = cdb_data;
                    end
                    if (!rdy2_q[i] && (tag2_q[i] == cdb_tag)) begin
                        rdy2_d[i] = 1'b1;
                        val2_d[i] = cdb_data;
                    end
                end
            end
            if (w_fire) begin
                valid_d[w_sel_idx] = 1'b0;
            end
            if (w_wr) begin
`ifdef RS_INT_AGE_EN
                for (int i = 0; i < ENTRIES; i++) begin
                    if (valid_q[i] && (IDX_W'(i) != w_free_idx) && (age_q[i] != '1)) begin
                        age_d[i] = age_q[i] + 1'b1;
                    end
                end
                age_d[w_free_idx] = '0;
`endif
                valid_d[w_free_idx] = 1'b1;
                op_d[w_free_idx]    = in_op;
                dest_d[w_free_idx]  = in_dest_tag;
                tag1_d[w_free_idx]  = in_src1_tag;
                tag2_d[w_free_idx]  = in_src2_tag;
                rdy1_d[w_free_idx]  = in_src1_rdy | w_byp1;
                rdy2_d[w_free_idx]  = in_src2_rdy | w_byp2;
                val1_d[w_free_idx]  = w_byp1 ? cdb_data : in_src1_val;
                val2_d[w_free_idx]  = w_byp2 ? cdb_data : in_src2_val;
            end
            count_d = count_q + CNT_W'(w_wr) - CNT_W'(w_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
`ifdef RS_INT_AGE_EN
                age_q[i]  <= '0;
`endif
            end
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            count_q <= count_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
`ifdef RS_INT_AGE_EN
            age_q   <= age_d;
`endif
        end
    end

    // Data outputs are forced to zero when nothing is selected.
    assign issue_valid    = w_sel_found;
    assign issue_op       = w_sel_found ? op_q[w_sel_idx]   : '0;
    assign issue_dest_tag = w_sel_found ? dest_q[w_sel_idx] : '0;
    assign issue_src1     = w_sel_found ? val1_q[w_sel_idx] : '0;
    assign issue_src2     = w_sel_found ? val2_q[w_sel_idx] : '0;

endmodule
`default_nettype wire
